// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // reset state, left on the first clock after release
        ST_REQ   = 2'd1,  // presenting a fetch request
        ST_WAIT  = 2'd2,  // granted, response still wanted
        ST_FLUSH = 2'd3   // granted, response will be thrown away
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [31:0] RST_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// One-entry output buffer holding the fetched instruction for decode.
// Latency: load/flush visible on the cycle after they are applied.
// Backpressure: entry is held while stall_i is high; flush beats load beats consume.
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   load_i            capture load_instr_i / load_pc_i as a valid entry
//   flush_i           drop the entry (redirect)
//   stall_i           decode cannot take the entry this cycle
//   valid_o, instr_o, pc_o, pc4_o   registered entry contents
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic         stall_i,
    input  logic [31:0]  load_instr_i,
    input  logic [W-1:0] load_pc_i,
    output logic         valid_o,
    output logic [31:0]  instr_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pc4_o
);

    logic consume;

    assign consume = valid_o && !stall_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            instr_o <= NOP_INSTR;
            pc_o    <= '0;
            pc4_o   <= W'(4);
        end else begin
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (load_i) begin
                valid_o <= 1'b1;
                instr_o <= load_instr_i;
                pc_o    <= load_pc_i;
                // Kept as a register so decode sees no adder on this path.
                pc4_o   <= load_pc_i + W'(4);
            end else if (consume) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and sequences one outstanding imem fetch.
// Latency: gnt at t, rvalid at t+k -> instr_valid_o and next request at t+k+1.
// Backpressure: no request while the buffer is full and stalled; redirects discard stale data.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   redirect_i, redirect_pc_i     taken branch/jump and its target (low 2 bits ignored)
//   stall_i                       decode cannot accept instr_o
//   imem_req_o/addr_o/gnt_i       request/grant side of the instruction memory
//   imem_rvalid_i/rdata_i         response side of the instruction memory
//   instr_valid_o/instr_o/instr_pc_o/instr_pc4_o   registered decode interface
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     W       = 32,
    parameter logic [W-1:0]    RST_VEC = W'(RST_VEC_DEFAULT)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         redirect_i,
    input  logic [W-1:0] redirect_pc_i,
    input  logic         stall_i,
    output logic         imem_req_o,
    output logic [W-1:0] imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    output logic         instr_valid_o,
    output logic [31:0]  instr_o,
    output logic [W-1:0] instr_pc_o,
    output logic [W-1:0] instr_pc4_o
);

    fetch_state_e state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] target;
    logic         req;
    logic         buf_load;

    // Word-align the redirect target.
    assign target = redirect_pc_i & ~W'(3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= RST_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req      = 1'b0;
        buf_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                // The buffer is guaranteed empty by the time any response
                // for this request can arrive, so one entry never overflows.
                req = !instr_valid_o || !stall_i;
                if (redirect_i) begin
                    pc_d = target;
                end
                if (req && imem_gnt_i) begin
                    // A redirect in the grant cycle makes the in-flight fetch stale.
                    state_d = redirect_i ? ST_FLUSH : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = imem_rvalid_i ? ST_REQ : ST_FLUSH;
                end else if (imem_rvalid_i) begin
                    buf_load = 1'b1;
                    pc_d     = pc_q + W'(4);
                    state_d  = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (redirect_i) begin
                    pc_d = target;
                end
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;

    // In WAIT pc_q is still the address of the outstanding fetch.
    fetch_buf #(
        .W (W)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (buf_load),
        .flush_i      (redirect_i),
        .stall_i      (stall_i),
        .load_instr_i (imem_rdata_i),
        .load_pc_i    (pc_q),
        .valid_o      (instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (instr_pc_o),
        .pc4_o        (instr_pc4_o)
    );

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that owns the program counter and sequences it against a single-outstanding, request/grant/response instruction memory port. It issues sequential fetches (PC+4), applies branch/jump redirects at any point in a transaction, and discards stale responses. It holds the fetched instruction in a one-entry output buffer until decode accepts it. It sits between the instruction memory and the decode stage and replaces free-running PC stepping in the core.

## Interface
- `W`, 32: address/PC width.
- `RST_VEC`, 32'h0000_0000: first fetch address after reset.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `redirect_i`  in  1  taken branch/jump this cycle.
- `redirect_pc_i`  in  W  redirect target; bits [1:0] ignored (treated as 0).
- `stall_i`  in  1  decode cannot accept `instr_o` this cycle.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  W  fetch address; stable while `imem_req_o` high and not granted.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response data valid.
- `imem_rdata_i`  in  32  response instruction.
- `instr_valid_o`  out  1  `instr_o` holds a valid instruction.
- `instr_o`  out  32  fetched instruction.
- `instr_pc_o`  out  W  address of `instr_o`.
- `instr_pc4_o`  out  W  `instr_pc_o + 4`, modulo 2^W.

## Operation
- Registers: `pc` (next fetch address), state, output buffer (`instr_o`, `instr_pc_o`, `instr_valid_o`).
- States:
  - IDLE: reset state only.
  - REQ: requesting.
  - WAIT: granted, awaiting response.
  - FLUSH: granted, response is stale.
- IDLE → REQ unconditionally on the first clock after reset release.
- REQ:
  - `imem_req_o = !instr_valid_o || !stall_i`; `imem_addr_o = pc`.
  - Request with gnt and no redirect → WAIT.
  - Request with gnt and redirect → FLUSH; `pc <= target`.
  - No gnt with redirect → `pc <= target`; stay REQ.
- WAIT:
  - rvalid with no redirect → load buffer (instr = rdata, pc = `pc`), `instr_valid_o <= 1`, `pc <= pc+4`, go to REQ.
  - rvalid with redirect → discard data, `pc <= target`, go to REQ.
  - Redirect without rvalid → `pc <= target`, go to FLUSH.
- FLUSH:
  - rvalid → discard data, go to REQ.
  - Redirect → `pc <= target`; stay in FLUSH.
- Buffer:
  - An instruction is consumed in any cycle where `instr_valid_o && !stall_i`. On consumption, `instr_valid_o` clears unless the buffer is reloaded in the same cycle.
  - `redirect_i` clears `instr_valid_o` next cycle. Redirect has priority over stall and over an rvalid load.
- Overflow impossible: a request issues only when the buffer empties by the cycle after the request.
- `imem_rvalid_i` in IDLE/REQ is a protocol error and is ignored.
- Arithmetic: `pc+4` wraps modulo 2^W; `redirect_pc_i[1:0]` is forced to 0 before being stored.

## Timing
- Reset values:
  - state = IDLE, `pc = RST_VEC`.
  - `imem_req_o = 0`, `imem_addr_o = RST_VEC`.
  - `instr_valid_o = 0`, `instr_o = 32'h0000_0013` (NOP).
  - `instr_pc_o = 0`, `instr_pc4_o = 4`.
- Reset is asserted asynchronously and may occur mid-transaction. Any outstanding response is not tracked after reset; memory must also be reset.
- First request is at cycle 1 after reset release.
- Gnt at cycle t and rvalid at t+k (k ≥ 1) → `instr_valid_o` high at t+k+1. The next request is also at t+k+1, so peak throughput is 1 instruction / 2 cycles.
- Redirect at cycle t → `imem_addr_o = target` at t+1 if in REQ. Otherwise the target is fetched in the first REQ cycle after the outstanding response drains.
- The `imem_*` handshake is combinational from state; all `instr_*` outputs are registered.

## Structure
- `fetch_pkg`: state enum, `NOP_INSTR = 32'h0000_0013`, default `RST_VEC`.
- Sub-module `fetch_buf`: one-entry output buffer with load/consume/flush. The FSM and `pc` stay in `fetch_ctrl`.

## Test plan
- Reset release with gnt=1 always and rvalid one cycle after gnt → addresses 0x0, 0x4, 0x8, …; `instr_pc_o` matches each; `instr_pc4_o` = +4.
- `stall_i` high for 5 cycles with a valid instruction at 0x8 → `instr_o` is held and no `imem_req_o` is issued. After stall drops, the next request goes to 0xC.
- Redirect to 0x100 during WAIT for 0x10, with rvalid 3 cycles later → data discarded; next request is 0x100; no `instr_valid_o` for 0x10.
- Redirect to 0x203 in the same cycle as a gnt for 0x20 → FLUSH; next request is 0x200.
- Gnt held low for 4 cycles → `imem_addr_o` stable. A redirect in cycle 2 switches the address the next cycle.
- Issue `pc = 0xFFFF_FFFC` by redirect and complete its fetch → next request goes to 0x0 (wrap) and `instr_pc4_o = 0x0`.
